// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_stage_pkg
// Shared types for the memory pipeline stage:
//   - word/address/strobe widths and the access-size encoding (msize_t)
//   - data-bus request/response bundles (dbus_req_t / dbus_resp_t)
//   - execute -> memory and memory -> writeback pipeline bundles
//   - memory-stage FSM state encoding and an alignment helper
// -----------------------------------------------------------------------------
package memory_stage_pkg;

    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [7:0]  strobe_t;

    // Access size: number of bytes is 1 << msize.
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        msize_t memsize;
        logic   memsext;
    } control_t;

    typedef struct packed {
        logic        valid;
        addr_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        word_t       aluout;   // effective address for memory ops, result otherwise
        word_t       memwd;    // store data, right-aligned
    } execute_data_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        addr_t       pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        control_t    ctl;
        word_t       result;
        logic        misalign;
    } memory_data_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    // An access is aligned when the low address bits below its size are zero.
    function automatic logic is_aligned(input logic [2:0] offset, input msize_t size);
        logic ok;
        unique case (size)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (offset[0] == 1'b0);
            MSIZE4:  ok = (offset[1:0] == 2'b00);
            default: ok = (offset == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/memory_stage_mem_format.sv
// -----------------------------------------------------------------------------
// memory_stage_mem_format
// Purely combinational byte-lane formatter for the data bus.
//   offset       in  byte offset of the access within the 64-bit word
//   size         in  access size
//   sext         in  sign-extend loaded data (else zero-extend)
//   store_data   in  right-aligned store data
//   load_data    in  raw 64-bit word returned by the bus
//   store_lane   out store data shifted into the addressed byte lanes
//   store_strobe out byte enables for the addressed lanes
//   load_result  out loaded value shifted down, truncated and extended
// -----------------------------------------------------------------------------
module memory_stage_mem_format
    import memory_stage_pkg::*;
(
    input  logic [2:0] offset,
    input  msize_t     size,
    input  logic       sext,
    input  word_t      store_data,
    input  word_t      load_data,
    output word_t      store_lane,
    output strobe_t    store_strobe,
    output word_t      load_result
);

    strobe_t strobe_base;
    word_t   load_shifted;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first); a missed branch would otherwise infer a latch.
    always_comb begin
        strobe_base  = 8'h00;
        store_lane   = store_data << {offset, 3'b000};
        load_shifted = load_data >> {offset, 3'b000};
        load_result  = '0;

        unique case (size)
            MSIZE1: begin
                strobe_base = 8'h01;
                load_result = {{56{sext & load_shifted[7]}}, load_shifted[7:0]};
            end
            MSIZE2: begin
                strobe_base = 8'h03;
                load_result = {{48{sext & load_shifted[15]}}, load_shifted[15:0]};
            end
            MSIZE4: begin
                strobe_base = 8'h0F;
                load_result = {{32{sext & load_shifted[31]}}, load_shifted[31:0]};
            end
            default: begin
                strobe_base = 8'hFF;
                load_result = load_shifted;
            end
        endcase

        store_strobe = strobe_base << offset;
    end

endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Pipeline stage after execute: issues loads/stores on the data bus, stalls
// upstream while an access is outstanding, and registers the result bundle
// for writeback.
//   clk     in  clock
//   reset   in  asynchronous, active-high reset
//   dataE   in  execute bundle (held stable by upstream while stallM=1)
//   dreq    out data-bus request (combinational from dataE)
//   dresp   in  data-bus response; data_ok marks completion
//   dataM   out registered memory bundle for writeback
//   stallM  out high while an aligned access has not yet seen data_ok
// -----------------------------------------------------------------------------
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          stallM
);

    mem_state_e   state_q, state_d;
    memory_data_t data_m_q, data_m_d;

    logic       mem_op;
    logic       aligned;
    logic       access;
    logic [2:0] offset;
    word_t      store_lane;
    strobe_t    store_strobe;
    word_t      load_result;

    // addr_ok only acknowledges the address phase; completion is data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign offset  = dataE.aluout[2:0];
    assign mem_op  = dataE.valid & (dataE.ctl.memread | dataE.ctl.memwrite);
    assign aligned = is_aligned(offset, dataE.ctl.memsize);
    // Reset gates the request directly so the bus sees valid drop at once,
    // even if upstream has not yet flushed dataE.
    assign access  = mem_op & aligned & ~reset;

    memory_stage_mem_format u_mem_format (
        .offset       (offset),
        .size         (dataE.ctl.memsize),
        .sext         (dataE.ctl.memsext),
        .store_data   (dataE.memwd),
        .load_data    (dresp.data),
        .store_lane   (store_lane),
        .store_strobe (store_strobe),
        .load_result  (load_result)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // Same-cycle data_ok completes without leaving IDLE.
                if (access && !dresp.data_ok) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Upstream holds the op, so losing it here means it was
                // flushed; either way there is nothing left to wait for.
                if (dresp.data_ok || !access) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // The request is rebuilt every cycle from the held dataE, which keeps
    // it bit-identical in BUSY without a separate request register.
    // ------------------------------------------------------------------
    always_comb begin
        dreq   = '0;
        stallM = 1'b0;
        if (access) begin
            dreq.valid = 1'b1;
            dreq.addr  = dataE.aluout;
            dreq.size  = dataE.ctl.memsize;
            if (dataE.ctl.memwrite) begin
                dreq.strobe = store_strobe;
                dreq.data   = store_lane;
            end
            stallM = ~dresp.data_ok;
        end
    end

    // ------------------------------------------------------------------
    // Writeback bundle register; a stall loads a bubble.
    // ------------------------------------------------------------------
    always_comb begin
        data_m_d = '0;
        if (!stallM) begin
            data_m_d.valid     = dataE.valid;
            data_m_d.pc        = dataE.pc;
            data_m_d.raw_instr = dataE.raw_instr;
            data_m_d.dst       = dataE.dst;
            data_m_d.ctl       = dataE.ctl;
            data_m_d.misalign  = mem_op & ~aligned;
            data_m_d.result    = (mem_op && aligned && dataE.ctl.memread)
                                 ? load_result : dataE.aluout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_m_q <= '0;
        end else begin
            data_m_q <= data_m_d;
        end
    end

    assign dataM = data_m_q;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
// Directed bench for memory_stage with a scoreboard of expected writeback
// bundles. Inputs change 1 ns after a rising edge; outputs are sampled 1 ns
// after that or 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    execute_data_t dataE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          stallM;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk    (clk),
        .reset  (reset),
        .dataE  (dataE),
        .dreq   (dreq),
        .dresp  (dresp),
        .dataM  (dataM),
        .stallM (stallM)
    );

    typedef struct {
        word_t result;
        logic  misalign;
        addr_t pc;
    } exp_t;

    exp_t      exp_q[$];
    int        compared   = 0;
    int        mismatched = 0;
    addr_t     pc_ctr;
    dbus_req_t first_req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic mr, input logic mw, input msize_t sz,
                            input logic sx, input addr_t a, input word_t wd);
        dataE              = '0;
        dataE.valid        = 1'b1;
        dataE.pc           = pc_ctr;
        dataE.raw_instr    = 32'h0000_0013 + pc_ctr[31:0];
        dataE.dst          = 5'd7;
        dataE.ctl.regwrite = mr;
        dataE.ctl.memread  = mr;
        dataE.ctl.memwrite = mw;
        dataE.ctl.memsize  = sz;
        dataE.ctl.memsext  = sx;
        dataE.aluout       = a;
        dataE.memwd        = wd;
        pc_ctr             = pc_ctr + 64'd4;
    endtask

    task automatic push_exp(input word_t result, input logic misalign);
        exp_q.push_back('{result: result, misalign: misalign, pc: dataE.pc});
    endtask

    task automatic expect_out(input string tag);
        exp_t e;
        compared++;
        assert (exp_q.size() > 0) else begin
            mismatched++;
            $error("FAIL %s: scoreboard empty, observed valid=%0b", tag, dataM.valid);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " valid"},    {63'd0, dataM.valid},    64'd1);
            check({tag, " result"},   dataM.result,            e.result);
            check({tag, " misalign"}, {63'd0, dataM.misalign}, {63'd0, e.misalign});
            check({tag, " pc"},       dataM.pc,                e.pc);
        end
    endtask

    initial begin
        pc_ctr = 64'h0000_0000_0000_1000;
        reset  = 1'b1;
        dataE  = '0;
        dresp  = '0;

        // Reset state
        #2;
        check("reset dataM zero", {63'd0, dataM === '0}, 64'd1);
        check("reset dreq.valid", {63'd0, dreq.valid},   64'd0);
        check("reset stallM",     {63'd0, stallM},       64'd0);
        check("reset state",      {63'd0, dut.state_q},  {63'd0, ST_IDLE});
        tick();
        reset = 1'b0;
        tick();

        // ALU op passes through in one cycle
        drive_op(1'b0, 1'b0, MSIZE8, 1'b0, 64'h1234, 64'd0);
        push_exp(64'h1234, 1'b0);
        #1;
        check("alu dreq.valid", {63'd0, dreq.valid}, 64'd0);
        check("alu stallM",     {63'd0, stallM},     64'd0);
        tick();
        expect_out("alu");
        dataE.valid = 1'b0;

        // ld, data_ok three cycles after issue
        drive_op(1'b1, 1'b0, MSIZE8, 1'b0, 64'h8000_0008, 64'd0);
        push_exp(64'hFFEE_DDCC_BBAA_9988, 1'b0);
        #1;
        first_req = dreq;
        check("ld dreq.valid",  {63'd0, dreq.valid},  64'd1);
        check("ld dreq.addr",   dreq.addr,            64'h8000_0008);
        check("ld dreq.size",   {62'd0, dreq.size},   {62'd0, MSIZE8});
        check("ld dreq.strobe", {56'd0, dreq.strobe}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("ld stallM",    {63'd0, stallM},            64'd1);
            check("ld dreq hold", {63'd0, dreq === first_req}, 64'd1);
            tick();
            check("ld bubble",    {63'd0, dataM.valid},       64'd0);
        end
        check("ld state busy", {63'd0, dut.state_q}, {63'd0, ST_BUSY});
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hFFEE_DDCC_BBAA_9988;
        #1;
        check("ld stallM at data_ok", {63'd0, stallM}, 64'd0);
        tick();
        expect_out("ld");

        // lb (sign-extend) then lbu back-to-back, both completing at issue
        drive_op(1'b1, 1'b0, MSIZE1, 1'b1, 64'h0000_0000_0000_0003, 64'd0);
        dresp.data_ok = 1'b1;
        dresp.data    = 64'h0000_0000_8000_0000;
        push_exp(64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        #1;
        check("lb dreq.valid", {63'd0, dreq.valid}, 64'd1);
        check("lb stallM",     {63'd0, stallM},     64'd0);
        tick();
        expect_out("lb");
        drive_op(1'b1, 1'b0, MSIZE1, 1'b0, 64'h0000_0000_0000_0003, 64'd0);
        push_exp(64'h80, 1'b0);
        #1;
        check("lbu dreq.valid", {63'd0, dreq.valid}, 64'd1);
        tick();
        expect_out("lbu");

        // sh at offset 6, completing at issue
        drive_op(1'b0, 1'b1, MSIZE2, 1'b0, 64'h0000_0000_0000_0006, 64'hABCD);
        dresp.data = 64'd0;
        push_exp(64'h6, 1'b0);
        #1;
        check("sh dreq.valid",  {63'd0, dreq.valid},  64'd1);
        check("sh dreq.strobe", {56'd0, dreq.strobe}, 64'hC0);
        check("sh dreq.lane",   {48'd0, dreq.data[63:48]}, 64'hABCD);
        check("sh dreq.data",   dreq.data,            64'hABCD_0000_0000_0000);
        check("sh dreq.size",   {62'd0, dreq.size},   {62'd0, MSIZE2});
        tick();
        expect_out("sh");

        // sw at offset 4, one wait cycle, addr_ok with data_ok together
        drive_op(1'b0, 1'b1, MSIZE4, 1'b0, 64'h0000_0000_0000_0004, 64'h1122_3344);
        dresp = '0;
        push_exp(64'h4, 1'b0);
        #1;
        check("sw dreq.strobe", {56'd0, dreq.strobe}, 64'hF0);
        check("sw dreq.data",   dreq.data,            64'h1122_3344_0000_0000);
        check("sw stallM",      {63'd0, stallM},      64'd1);
        tick();
        check("sw bubble", {63'd0, dataM.valid}, 64'd0);
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        #1;
        check("sw stallM at data_ok", {63'd0, stallM}, 64'd0);
        tick();
        expect_out("sw");
        check("sw state idle", {63'd0, dut.state_q}, {63'd0, ST_IDLE});

        // Misaligned lw: no bus request, flagged pass-through
        dresp = '0;
        drive_op(1'b1, 1'b0, MSIZE4, 1'b0, 64'h0000_0000_0000_0002, 64'd0);
        push_exp(64'h2, 1'b1);
        #1;
        check("lw-mis dreq.valid", {63'd0, dreq.valid}, 64'd0);
        check("lw-mis stallM",     {63'd0, stallM},     64'd0);
        tick();
        expect_out("lw-mis");

        // Reset while BUSY, then a stale data_ok
        drive_op(1'b1, 1'b0, MSIZE8, 1'b0, 64'h0000_0000_0000_0010, 64'd0);
        #1;
        check("rst ld stallM", {63'd0, stallM}, 64'd1);
        tick();
        check("rst ld busy", {63'd0, dut.state_q}, {63'd0, ST_BUSY});
        #2;
        reset = 1'b1;
        #1;
        check("rst dreq.valid", {63'd0, dreq.valid},  64'd0);
        check("rst dataM.valid", {63'd0, dataM.valid}, 64'd0);
        check("rst stallM",     {63'd0, stallM},      64'd0);
        check("rst state",      {63'd0, dut.state_q}, {63'd0, ST_IDLE});
        dataE.valid = 1'b0;
        tick();
        reset         = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("late data_ok dreq.valid", {63'd0, dreq.valid}, 64'd0);
        tick();
        check("late data_ok dataM.valid", {63'd0, dataM.valid}, 64'd0);
        check("late data_ok state",       {63'd0, dut.state_q}, {63'd0, ST_IDLE});
        dresp = '0;

        // Pipeline still works after reset
        drive_op(1'b0, 1'b0, MSIZE8, 1'b0, 64'h55, 64'd0);
        push_exp(64'h55, 1'b0);
        tick();
        expect_out("post-rst alu");
        dataE.valid = 1'b0;
        tick();

        compared++;
        assert (exp_q.size() == 0) else begin
            mismatched++;
            $error("FAIL scoreboard drain: observed=%0d leftover expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute: consumes execute_data_t and performs the load/store on the data bus (dbus).
- Produces a registered memory_data_t for writeback.
- Holds the dbus request stable until the bus completes it, and asserts a stall toward upstream stages while the access is pending.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- None. All widths come from the common package: word_t is 64 bits, addr_t is 64 bits, strobe_t is 8 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- dataE  in  execute_data_t  upstream bundle: valid, pc, raw_instr, dst, ctl, aluout (address or result), memwd (store data)
- dreq  out  dbus_req_t  valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[63:0]
- dataM  out  memory_data_t  registered: valid, pc, raw_instr, dst, ctl, result[63:0], misalign
- stallM  out  1  high while an access is outstanding; upstream must hold dataE stable

Behaviour:
Reset:
- State is IDLE.
- dataM is all-zero (dataM.valid=0).
- dreq.valid=0.

Access decode:
- An instruction is a memory op when dataE.valid and (ctl.memread or ctl.memwrite).
- Address = dataE.aluout.

Alignment:
- The address is aligned when addr mod size_bytes == 0, with size_bytes ∈ {1,2,4,8} from ctl.memsize.
- A misaligned memory op issues no bus request.
- It passes through in one cycle with dataM.misalign=1 and result=address.

Store formatting:
- Byte offset = addr[2:0].
- dreq.data = memwd replicated/shifted into the lane at that offset.
- dreq.strobe covers that many bytes: 0x01, 0x03, 0x0F or 0xFF, shifted left by the offset.
- Loads use strobe = 0.

Load formatting:
- Take dresp.data, shift right by offset×8, truncate to size.
- Sign-extend if ctl.memsext, else zero-extend, to 64 bits.

FSM states: IDLE, BUSY.
- IDLE, aligned memory op present:
  - Drive dreq.valid=1 with addr/size/strobe/data combinationally, in the same cycle.
  - If dresp.data_ok in that same cycle: the access completes and the state stays IDLE.
  - Otherwise go to BUSY.
- BUSY:
  - dreq is held bit-identical; the upstream is stalled, so the request is recomputed from the held dataE.
  - When dresp.data_ok is seen, return to IDLE.
- addr_ok is informational only. Completion is data_ok alone; addr_ok and data_ok arriving together is legal.

Stall:
- stallM = memory op is aligned and data_ok not yet seen, combinational in both IDLE and BUSY.
- While stallM=1, the dataM register loads a bubble (valid=0).

Output register, on each clk edge with stallM=0:
- dataM takes dataE.valid, pc, raw_instr, dst and ctl.
- result = formatted load data for loads, else aluout. Stores pass aluout.
- dataE.valid=0 produces dataM.valid=0 and no bus request.

Latency:
- Non-memory op and misaligned op: 1 cycle.
- Memory op: (cycles until data_ok) + 1. The minimum is 1 when data_ok arrives in the issue cycle.

Back-to-back memory ops:
- The next request may be asserted in the cycle after completion, with no idle gap required.

Reset mid-access:
- Asynchronously returns to IDLE and drops dreq.valid and dataM.valid.
- A late data_ok arriving after reset is ignored.

Decomposition:
- Add msize_t and the dbus_req_t/dbus_resp_t typedefs to common, if absent.
- Add memory_data_t and the control_t fields memread, memwrite, memsize and memsext to pipes.
- One natural sub-module: mem_format, which is combinational. It generates store lane/strobe data and performs load shift/extend from (addr[2:0], size, sext).

Test Plan:
- ALU op, dataE.aluout=0x1234, valid=1 → next edge dataM.result=0x1234, valid=1; dreq.valid=0; stallM never asserted.
- ld at 0x80000008, data_ok after 3 cycles with data 0xFFEE_DDCC_BBAA_9988:
  - stallM high 3 cycles; dreq stable.
  - dataM.result=0xFFEEDDCCBBAA9988 one edge after data_ok.
- lb (sext) at 0x...0003, dresp.data=0x00000000_80000000 → result=0xFFFFFFFFFFFFFF80. lbu at the same address and data → 0x80.
- sh at 0x...0006, memwd=0xABCD → dreq.strobe=0xC0, dreq.data[63:48]=0xABCD, dreq.size=2 bytes.
- lw at 0x...0002 (misaligned) → no dreq.valid; next edge dataM.misalign=1, result=0x...0002.
- Reset asserted while in BUSY → dreq.valid and dataM.valid drop immediately. After release, a pending data_ok produces no output and the state is IDLE.
